// File: rtl/matrix_addsub_seq_if.sv
// Handshake bundle for matrix_addsub_seq: operand side (in_*), result side (out_*),
// plus status. The master modport is the surrounding datapath; slave is the block.
interface matrix_addsub_seq_if #(
    parameter int W    = 3,
    parameter int ROWS = 2,
    parameter int COLS = 2
);
    localparam int N = ROWS * COLS;

    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic [N*W-1:0]     a_flat;
    logic [N*W-1:0]     b_flat;
    logic               out_valid;
    logic               out_ready;
    logic [N*(W+1)-1:0] c_flat;
    logic               msb_any;
    logic               busy;

    modport master (
        output in_valid, mode, a_flat, b_flat, out_ready,
        input  in_ready, out_valid, c_flat, msb_any, busy
    );

    modport slave (
        input  in_valid, mode, a_flat, b_flat, out_ready,
        output in_ready, out_valid, c_flat, msb_any, busy
    );
endinterface

// File: rtl/matrix_addsub_seq.sv
// Sequential ROWS x COLS element-wise add/subtract: one element per clock through a
// single shared (W+1)-bit adder, result presented on a valid/ready handshake.
module matrix_addsub_seq #(
    parameter int W    = 3,
    parameter int ROWS = 2,
    parameter int COLS = 2
) (
    input logic                clk,
    input logic                rst,
    matrix_addsub_seq_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [N*W-1:0]     a_q, a_d;
    logic [N*W-1:0]     b_q, b_d;
    logic               mode_q, mode_d;
    logic [N*(W+1)-1:0] c_q, c_d;
    logic               msb_q, msb_d;

    logic [W-1:0]       a_el;
    logic [W-1:0]       b_el;
    logic [W:0]         elem;

    always_comb begin
        a_el = a_q[int'(idx_q)*W +: W];
        b_el = b_q[int'(idx_q)*W +: W];
        // Inverting B over W+1 bits (not W) makes bit W the true sign of A-B.
        elem = {1'b0, a_el} + ({1'b0, b_el} ^ {(W+1){mode_q}}) + {{W{1'b0}}, mode_q};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        c_d     = c_q;
        msb_d   = msb_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_flat;
                    b_d     = bus.b_flat;
                    mode_d  = bus.mode;
                    c_d     = '0;
                    msb_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d[int'(idx_q)*(W+1) +: (W+1)] = elem;
                msb_d = msb_q | elem[W];
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            c_q     <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            msb_q   <= msb_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.c_flat    = c_q;
    assign bus.msb_any   = msb_q;
endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Randomised and directed checks of matrix_addsub_seq in 2x2/W=3, 3x3/W=8 and 1x1/W=3
// configurations against an arithmetic reference model.
module tb_matrix_addsub_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    matrix_addsub_seq_if #(.W(3), .ROWS(2), .COLS(2)) bus0 ();
    matrix_addsub_seq_if #(.W(8), .ROWS(3), .COLS(3)) bus1 ();
    matrix_addsub_seq_if #(.W(3), .ROWS(1), .COLS(1)) bus2 ();

    matrix_addsub_seq #(.W(3), .ROWS(2), .COLS(2)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    matrix_addsub_seq #(.W(8), .ROWS(3), .COLS(3)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    matrix_addsub_seq #(.W(3), .ROWS(1), .COLS(1)) u2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Element i: A+B, or (A-B) mod 2^(w+1); packed at i*(w+1).
    function automatic logic [127:0] ref_c(input int unsigned w, input int unsigned n,
                                           input logic [127:0] a, input logic [127:0] b,
                                           input logic m);
        logic [127:0] r;
        longint unsigned ai, bi, ci, lim;
        r   = '0;
        lim = 64'd1 << w;
        for (int unsigned i = 0; i < n; i++) begin
            ai = 64'(a >> (i * w)) % lim;
            bi = 64'(b >> (i * w)) % lim;
            ci = m ? (ai + 2 * lim - bi) % (2 * lim) : ai + bi;
            r  = r | (128'(ci) << (i * (w + 1)));
        end
        return r;
    endfunction

    function automatic logic ref_msb(input int unsigned w, input int unsigned n,
                                     input logic [127:0] a, input logic [127:0] b,
                                     input logic m);
        longint unsigned ai, bi, lim;
        logic any;
        any = 1'b0;
        lim = 64'd1 << w;
        for (int unsigned i = 0; i < n; i++) begin
            ai = 64'(a >> (i * w)) % lim;
            bi = 64'(b >> (i * w)) % lim;
            if (m ? (ai < bi) : (ai + bi >= lim)) any = 1'b1;
        end
        return any;
    endfunction

    task automatic txn0(input logic [127:0] a, input logic [127:0] b, input logic m,
                        input int unsigned hold, input string tag);
        logic [127:0] ec;
        int unsigned t;
        ec = ref_c(3, 4, a, b, m);
        bus0.a_flat = 12'(a); bus0.b_flat = 12'(b); bus0.mode = m; bus0.in_valid = 1'b1;
        t = 0;
        while (bus0.in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        chk({tag, "_rdy"}, bus0.in_ready, 1);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        bus0.a_flat = 12'(rnd()); bus0.b_flat = 12'(rnd()); bus0.mode = ~m;
        chk({tag, "_busy"}, bus0.busy, 1);
        t = 0;
        while (bus0.out_valid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        chk({tag, "_lat"}, t, 4);
        chk({tag, "_c"}, bus0.c_flat, ec);
        chk({tag, "_msb"}, bus0.msb_any, ref_msb(3, 4, a, b, m));
        for (int unsigned h = 0; h < hold; h++) begin
            bus0.in_valid = 1'b1;
            bus0.a_flat = 12'(rnd()); bus0.b_flat = 12'(rnd()); bus0.mode = $urandom_range(0, 1);
            @(posedge clk); #1;
            chk({tag, "_hold_c"}, bus0.c_flat, ec);
            chk({tag, "_hold_ov"}, bus0.out_valid, 1);
            chk({tag, "_hold_ir"}, bus0.in_ready, 0);
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        chk({tag, "_idle_ov"}, bus0.out_valid, 0);
        chk({tag, "_idle_ir"}, bus0.in_ready, 1);
        chk({tag, "_idle_c"}, bus0.c_flat, ec);
    endtask

    task automatic txn1(input logic [127:0] a, input logic [127:0] b, input logic m,
                        input string tag);
        int unsigned t;
        bus1.a_flat = 72'(a); bus1.b_flat = 72'(b); bus1.mode = m; bus1.in_valid = 1'b1;
        t = 0;
        while (bus1.in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        t = 0;
        while (bus1.out_valid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        chk({tag, "_lat"}, t, 9);
        chk({tag, "_c"}, bus1.c_flat, ref_c(8, 9, a, b, m));
        chk({tag, "_msb"}, bus1.msb_any, ref_msb(8, 9, a, b, m));
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        chk({tag, "_ir"}, bus1.in_ready, 1);
    endtask

    task automatic txn2(input logic [127:0] a, input logic [127:0] b, input logic m,
                        input string tag);
        int unsigned t;
        bus2.a_flat = 3'(a); bus2.b_flat = 3'(b); bus2.mode = m; bus2.in_valid = 1'b1;
        t = 0;
        while (bus2.in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        t = 0;
        while (bus2.out_valid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        chk({tag, "_lat"}, t, 1);
        chk({tag, "_c"}, bus2.c_flat, ref_c(3, 1, a, b, m));
        chk({tag, "_msb"}, bus2.msb_any, ref_msb(3, 1, a, b, m));
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
        chk({tag, "_ir"}, bus2.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a1, b1, a2, b2;
        int unsigned t;

        bus0.in_valid = 1'b0; bus0.mode = 1'b0; bus0.a_flat = '0; bus0.b_flat = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.mode = 1'b0; bus1.a_flat = '0; bus1.b_flat = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.mode = 1'b0; bus2.a_flat = '0; bus2.b_flat = '0; bus2.out_ready = 1'b0;
        #12;
        chk("rst_ir", bus0.in_ready, 1);
        chk("rst_ov", bus0.out_valid, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_c", bus0.c_flat, 0);
        chk("rst_msb", bus0.msb_any, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        txn0({3'd7, 3'd0, 3'd3, 3'd5}, {3'd7, 3'd1, 3'd4, 3'd2}, 1'b0, 0, "add0");
        chk("add0_lit", bus0.c_flat, 16'hE177);
        chk("add0_lmsb", bus0.msb_any, 1);
        txn0({3'd0, 3'd4, 3'd7, 3'd2}, {3'd7, 3'd4, 3'd0, 3'd5}, 1'b1, 0, "sub0");
        chk("sub0_lit", bus0.c_flat, 16'h907D);
        chk("sub0_lmsb", bus0.msb_any, 1);
        txn0({3'd4, 3'd5, 3'd6, 3'd7}, {3'd1, 3'd1, 3'd1, 3'd1}, 1'b1, 0, "sub1");
        chk("sub1_lit", bus0.c_flat, 16'h3456);
        chk("sub1_lmsb", bus0.msb_any, 0);
        txn0(rnd(), rnd(), 1'($urandom_range(0, 1)), 5, "bp");

        bus0.a_flat = 12'hFFF; bus0.b_flat = 12'hFFF; bus0.mode = 1'b0; bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ir", bus0.in_ready, 1);
        chk("mid_rst_ov", bus0.out_valid, 0);
        chk("mid_rst_busy", bus0.busy, 0);
        chk("mid_rst_c", bus0.c_flat, 0);
        chk("mid_rst_msb", bus0.msb_any, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        txn0({4{3'd1}}, {4{3'd1}}, 1'b0, 0, "post_rst");
        chk("post_rst_lit", bus0.c_flat, 16'h2222);

        // Back-to-back with in_valid held high and out_ready high; mode flips add -> sub.
        a1 = rnd(); b1 = rnd(); a2 = rnd(); b2 = rnd();
        bus0.out_ready = 1'b1;
        bus0.a_flat = 12'(a1); bus0.b_flat = 12'(b1); bus0.mode = 1'b0; bus0.in_valid = 1'b1;
        chk("b2b_rdy", bus0.in_ready, 1);
        @(posedge clk); #1;
        bus0.a_flat = 12'(a2); bus0.b_flat = 12'(b2); bus0.mode = 1'b1;
        t = 0;
        while (bus0.out_valid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        chk("b2b1_lat", t, 4);
        chk("b2b1_c", bus0.c_flat, ref_c(3, 4, a1, b1, 1'b0));
        @(posedge clk); #1;
        chk("b2b_gap_ir", bus0.in_ready, 1);
        chk("b2b_gap_ov", bus0.out_valid, 0);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        chk("b2b2_busy", bus0.busy, 1);
        t = 0;
        while (bus0.out_valid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        chk("b2b2_lat", t, 4);
        chk("b2b2_c", bus0.c_flat, ref_c(3, 4, a2, b2, 1'b1));
        chk("b2b2_msb", bus0.msb_any, ref_msb(3, 4, a2, b2, 1'b1));
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        chk("b2b_end_ir", bus0.in_ready, 1);

        for (int i = 0; i < 20; i++) begin
            txn0(rnd(), rnd(), 1'($urandom_range(0, 1)), $urandom_range(0, 2), "rnd0");
        end

        txn1({9{8'hFF}}, {9{8'hFF}}, 1'b0, "max1");
        chk("max1_lit", bus1.c_flat, {9{9'h1FE}});
        chk("max1_lmsb", bus1.msb_any, 1);
        for (int i = 0; i < 6; i++) begin
            txn1(rnd(), rnd(), 1'($urandom_range(0, 1)), "rnd1");
        end

        for (int i = 0; i < 8; i++) begin
            txn2(rnd(), rnd(), 1'($urandom_range(0, 1)), "rnd2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
